// File: rtl/pdh_dma_pkg.sv
// Shared types and AXI constants for the PDH sample DMA master.
package pdh_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } dma_state_e;

  localparam int BURST_BEATS = 16;
  localparam int BEAT_BYTES  = 8;
  localparam int BURST_BYTES = BURST_BEATS * BEAT_BYTES;

  localparam logic [3:0] AXI_LEN_16     = 4'(BURST_BEATS - 1);
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_STRB_ALL   = 8'hFF;
  localparam logic [3:0] LAST_BEAT      = 4'(BURST_BEATS - 1);

  // Ring pointer step; the wrap compare assumes BUF_BYTES is a multiple of a burst.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr,
                                           input logic [31:0] base,
                                           input logic [31:0] bytes);
    logic [31:0] step;
    step = ptr + 32'(BURST_BYTES);
    return (step == base + bytes) ? base : step;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: q pulses for one cycle after d goes 0->1.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
      q   <= 1'b0;
    end else begin
      d_q <= d;
      q   <= d & ~d_q;
    end
  end

endmodule

// File: rtl/dma_controller.sv
// Write-only AXI DMA master: one 16x64-bit INCR burst per enable_i rising edge into a DDR ring.
//   state   | meaning
//   IDLE    | waiting for a synchronized enable_i rising edge
//   ADDR    | awvalid held until the address is accepted
//   DATA    | streaming 16 beats, fresh data_i sample per accepted beat
//   RESP    | bready held until the write response arrives
import pdh_dma_pkg::*;

module dma_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h1E00_0000,
  parameter logic [31:0] BUF_BYTES = 32'h0010_0000
) (
  input  logic        aclk,
  input  logic        rst_i,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [3:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [63:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        enable_i,
  input  logic [63:0] data_i,
  output logic        finished_o,
  output logic        engaged_o
);

  dma_state_e  state;
  logic [31:0] ptr;
  logic [3:0]  beat;
  logic        enable_meta_w;
  logic        enable_sync_w;
  logic        trigger;
  logic        b_done;

  assign m_axi_awlen   = AXI_LEN_16;
  assign m_axi_awsize  = AXI_SIZE_8B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb   = AXI_STRB_ALL;
  assign engaged_o     = (state != ST_IDLE);

  // Any response code completes the burst; bresp is folded in only so it is not left dangling.
  assign b_done = m_axi_bvalid & m_axi_bready & ((|m_axi_bresp) | ~(|m_axi_bresp));

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      enable_meta_w <= 1'b0;
      enable_sync_w <= 1'b0;
    end else begin
      enable_meta_w <= enable_i;
      enable_sync_w <= enable_meta_w;
    end
  end

  edge_rise u_edge_rise (
    .clk (aclk),
    .rst (rst_i),
    .d   (enable_sync_w),
    .q   (trigger)
  );

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      ptr           <= BASE_ADDR;
      beat          <= 4'd0;
      m_axi_awaddr  <= BASE_ADDR;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= 64'd0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
      finished_o    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (trigger) begin
            m_axi_awaddr  <= ptr;
            m_axi_awvalid <= 1'b1;
            finished_o    <= 1'b0;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wdata   <= data_i;
            m_axi_wlast   <= 1'b0;
            beat          <= 4'd0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_axi_wready) begin
            if (beat == LAST_BEAT) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              m_axi_bready <= 1'b1;
              state        <= ST_RESP;
            end else begin
              beat        <= beat + 4'd1;
              m_axi_wdata <= data_i;
              m_axi_wlast <= (beat == LAST_BEAT - 4'd1);
            end
          end
        end
        ST_RESP: begin
          if (b_done) begin
            m_axi_bready <= 1'b0;
            finished_o   <= 1'b1;
            ptr          <= next_ptr(ptr, BASE_ADDR, BUF_BYTES);
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: AXI slave driver, expectation queues and a decoupled monitor.
module tb_dma_controller;

  localparam logic [31:0] BASE = 32'h1E00_0000;
  localparam logic [31:0] BUF  = 32'h0000_0100;

  logic        aclk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [3:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [63:0] m_axi_wdata;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        enable_i = 1'b0;
  logic [63:0] data_i = 64'd0;
  logic        finished_o;
  logic        engaged_o;

  dma_controller #(.BASE_ADDR(BASE), .BUF_BYTES(BUF)) dut (
    .aclk(aclk), .rst_i(rst_i),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .enable_i(enable_i), .data_i(data_i), .finished_o(finished_o), .engaged_o(engaged_o)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_aw[$];
  logic [64:0] exp_w[$];
  int aw_seen = 0, w_seen = 0, b_seen = 0;

  // Slave behaviour knobs, written by the stimulus process only.
  bit          stall = 1'b0;
  int          aw_delay = 0;
  int          b_delay = 0;
  logic [63:0] seed = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // AXI slave: decides ready/valid and the data_i sample for the upcoming edge.
  int cyc = 0, ld_cnt = 0, aw_wait = 0, b_cnt = 0;
  bit last_pend = 0, b_pend = 0, b_drop = 0;
  always @(negedge aclk) begin
    cyc++;
    if (!engaged_o) ld_cnt = 0;
    if (b_drop) begin m_axi_bvalid = 1'b0; b_drop = 0; b_pend = 0; end
    if (last_pend) begin last_pend = 0; b_pend = 1; b_cnt = b_delay; end
    if (b_pend && !m_axi_bvalid) begin
      if (b_cnt == 0) m_axi_bvalid = 1'b1;
      else b_cnt--;
    end
    if (!m_axi_awvalid) begin
      aw_wait = 0;
      m_axi_awready = (aw_delay == 0);
    end else begin
      m_axi_awready = (aw_wait >= aw_delay);
      aw_wait++;
    end
    m_axi_wready = !stall || (cyc % 4 != 3);
    if (m_axi_wvalid && m_axi_wready && m_axi_wlast) last_pend = 1;
    if (m_axi_bvalid && m_axi_bready) b_drop = 1;
    if ((m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready && !m_axi_wlast)) begin
      data_i = seed + 64'(ld_cnt);
      ld_cnt++;
    end else begin
      data_i = {32'hBAD0_0000, 32'(cyc)};
    end
  end

  // Monitor: pops expectations on every handshake, checks hold behaviour under stall.
  bit          prev_stall = 0;
  logic [63:0] prev_wdata = 64'd0;
  logic        prev_wlast = 1'b0;
  always begin
    @(negedge aclk);
    #2;
    if (!rst_i) begin
      if (prev_stall) begin
        check("w_hold_data", m_axi_wdata, prev_wdata);
        check("w_hold_last", 64'(m_axi_wlast), 64'(prev_wlast));
        check("w_hold_valid", 64'(m_axi_wvalid), 64'd1);
      end
      if (m_axi_awvalid && m_axi_awready) begin
        aw_seen++;
        if (exp_aw.size() == 0) flag("unexpected_aw");
        else check("awaddr", 64'(m_axi_awaddr), 64'(exp_aw.pop_front()));
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_seen++;
        if (exp_w.size() == 0) flag("unexpected_w");
        else begin
          logic [64:0] e;
          e = exp_w.pop_front();
          check("wdata", m_axi_wdata, e[63:0]);
          check("wlast", 64'(m_axi_wlast), 64'(e[64]));
        end
      end
      if (m_axi_bvalid && m_axi_bready) b_seen++;
    end
    prev_stall = m_axi_wvalid && !m_axi_wready && !rst_i;
    prev_wdata = m_axi_wdata;
    prev_wlast = m_axi_wlast;
  end

  logic [31:0] model_ptr = BASE;
  int aw0 = 0, w0 = 0, b0 = 0;

  task automatic fire(input logic [63:0] s);
    int n;
    seed = s;
    exp_aw.push_back(model_ptr);
    for (int k = 0; k < 16; k++) exp_w.push_back({k == 15, s + 64'(k)});
    model_ptr = (model_ptr + 32'd128 == BASE + BUF) ? BASE : model_ptr + 32'd128;
    aw0 = aw_seen; w0 = w_seen; b0 = b_seen;
    @(posedge aclk); #1;
    enable_i = 1'b1;
    n = 0;
    while (!m_axi_awvalid && n < 20) begin @(posedge aclk); #1; n++; end
    check("awvalid_latency", 64'(n), 64'd4);
    check("engaged_on_start", 64'(engaged_o), 64'd1);
    check("finished_cleared", 64'(finished_o), 64'd0);
    enable_i = 1'b0;
  endtask

  task automatic wait_done(input int beats);
    int n;
    n = 0;
    while (!finished_o && n < 300) begin @(posedge aclk); #1; n++; end
    check("finished_set", 64'(finished_o), 64'd1);
    check("engaged_clear", 64'(engaged_o), 64'd0);
    check("beat_count", 64'(w_seen - w0), 64'(beats));
    check("aw_count", 64'(aw_seen - aw0), 64'd1);
    check("b_count", 64'(b_seen - b0), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    rst_i = 1'b0;
    check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("rst_wlast", 64'(m_axi_wlast), 64'd0);
    check("rst_bready", 64'(m_axi_bready), 64'd0);
    check("rst_awaddr", 64'(m_axi_awaddr), 64'(BASE));
    check("rst_wdata", m_axi_wdata, 64'd0);
    check("rst_finished", 64'(finished_o), 64'd0);
    check("rst_engaged", 64'(engaged_o), 64'd0);
    check("const_awlen", 64'(m_axi_awlen), 64'd15);
    check("const_awsize", 64'(m_axi_awsize), 64'd3);
    check("const_awburst", 64'(m_axi_awburst), 64'd1);
    check("const_wstrb", 64'(m_axi_wstrb), 64'hFF);
    repeat (2) @(posedge aclk);

    // Clean burst, no back-pressure.
    fire(64'h1111_0000_0000_0000);
    wait_done(16);
    repeat (5) @(posedge aclk);

    // Address, data and response stalls.
    stall = 1'b1; aw_delay = 3; b_delay = 3;
    fire(64'h2222_0000_0000_0100);
    wait_done(16);
    stall = 1'b0; aw_delay = 0; b_delay = 0;
    repeat (5) @(posedge aclk);

    // Retrigger while engaged is dropped.
    fire(64'h3333_0000_0000_0200);
    repeat (2) @(posedge aclk);
    #1 enable_i = 1'b1;
    repeat (3) @(posedge aclk);
    #1 enable_i = 1'b0;
    wait_done(16);
    repeat (12) @(posedge aclk);
    #1;
    check("retrigger_aw", 64'(aw_seen - aw0), 64'd1);
    check("retrigger_idle", 64'(engaged_o), 64'd0);
    check("retrigger_finished", 64'(finished_o), 64'd1);

    // Ring wrap over a two-burst buffer.
    for (int t = 0; t < 3; t++) begin
      fire(64'h4444_0000_0000_0000 + 64'(t * 64));
      wait_done(16);
      repeat (4) @(posedge aclk);
    end

    // Reset in the middle of a burst.
    fire(64'h5555_0000_0000_0000);
    begin
      int n;
      n = 0;
      while (w_seen - w0 < 7 && n < 100) begin @(posedge aclk); #3; n++; end
      check("reach_beat7", 64'(w_seen - w0 >= 7), 64'd1);
    end
    rst_i = 1'b1;
    @(posedge aclk);
    #1;
    check("abort_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("abort_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("abort_wlast", 64'(m_axi_wlast), 64'd0);
    check("abort_bready", 64'(m_axi_bready), 64'd0);
    check("abort_awaddr", 64'(m_axi_awaddr), 64'(BASE));
    check("abort_finished", 64'(finished_o), 64'd0);
    check("abort_engaged", 64'(engaged_o), 64'd0);
    exp_w.delete();
    exp_aw.delete();
    model_ptr = BASE;
    rst_i = 1'b0;
    repeat (4) @(posedge aclk);
    fire(64'h5656_0000_0000_0000);
    wait_done(16);
    repeat (4) @(posedge aclk);

    // Ascending samples; finished_o clears on the new trigger (checked inside fire).
    fire(64'h0000_0000_0000_0001);
    wait_done(16);
    repeat (4) @(posedge aclk);

    check("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    check("w_queue_drained", 64'(exp_w.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
